mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency word memory between the MIPS core's instruction-fetch port (I, read-only)
//  and its load/store port (D, read/write). One access is in flight at a time. Data accesses win by default.
//  A streak limit stops fetch from starving. Sits between the core's IF/MEM stages and the unified memory;
//  the core stalls on missing *_rdy.
// PARAMETERS
//  ADDR_W      32  byte-address width on I/D ports; mem_addr is word address [ADDR_W-1:2]
//  LAT         1   memory read latency in cycles after the mem_en cycle (legal >= 1)
//  MAX_STREAK  4   consecutive D grants allowed while i_req waits before I is forced (legal >= 1)
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  i_req      in   1         fetch request; held with i_addr stable until i_rdy
//  i_addr     in   ADDR_W    fetch byte address ([1:0] ignored)
//  i_rdy      out  1         one-cycle pulse: fetch complete, i_rdata valid this cycle
//  i_rdata    out  32        fetched word, held until next I completion
//  d_req      in   1         load/store request; d_we/d_be/d_addr/d_wdata stable until d_rdy
//  d_we       in   1         1 = store, 0 = load
//  d_be       in   4         store byte enables (ignored for loads)
//  d_addr     in   ADDR_W    data byte address ([1:0] ignored)
//  d_wdata    in   32        store data
//  d_rdy      out  1         one-cycle pulse: load/store complete
//  d_rdata    out  32        load data; updated on load completion only, held otherwise
//  mem_en     out  1         memory access strobe, high exactly one cycle per access
//  mem_we     out  1         memory write enable, qualified by mem_en
//  mem_be     out  4         memory byte enables (4'hF for reads)
//  mem_addr   out  ADDR_W-2  memory word address
//  mem_wdata  out  32        memory write data
//  mem_rdata  in   32        memory read data, valid exactly LAT cycles after the mem_en cycle
//  busy       out  1         high whenever state != IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, streak=0. All outputs 0, including i_rdata and d_rdata.
//  - All outputs are registered; no combinational path from requests to outputs.
//  - FSM IDLE -> ISSUE -> WAIT(LAT cycles) -> RESP -> IDLE.
//    - IDLE: if any req, arbitrate, latch owner, load mem_* regs -> ISSUE. Otherwise stay.
//    - ISSUE: mem_en=1 for this cycle only; cnt <= LAT-1 -> WAIT.
//    - WAIT: decrement cnt. When cnt==0, capture mem_rdata into owner's rdata (loads/fetches only) -> RESP.
//    - RESP: owner's rdy=1 for one cycle -> IDLE. Requests are not sampled in RESP.
//  - Latency: req first seen in IDLE at cycle t0 -> mem_en at t0+1 -> rdy at t0+LAT+2.
//    Peak throughput is one access per LAT+3 cycles.
//  - Arbitration in IDLE:
//    - Only one req: grant it.
//    - Both reqs: grant D, unless streak==MAX_STREAK, then grant I.
//    - Streak update: D grant with i_req high -> streak+1. Any I grant -> streak=0.
//      D grant with i_req low -> streak=0. Streak saturates at MAX_STREAK.
//  - Fetch: mem_we=0, mem_be=4'hF, mem_addr=i_addr[ADDR_W-1:2].
//  - Load: mem_we=0, mem_be=4'hF.
//  - Store: mem_we=1, mem_be=d_be, mem_wdata=d_wdata. The store takes the full ISSUE/WAIT/RESP path;
//    d_rdata is unchanged.
//  - mem_we/mem_be/mem_addr/mem_wdata hold their values from ISSUE until the next grant.
//  - Req dropped before rdy (protocol violation): the access still completes and rdy still pulses.
//  - Reset mid-access: immediate return to IDLE, no rdy issued. A store in flight may or may not have
//    committed; requesters must re-issue.
// TESTING
//  - Reset: hold reset=0 with reqs high -> mem_en=0, busy=0, rdy=0, rdata=0. Release with LAT=2, i_req,
//    i_addr=0x00400004 -> mem_en one cycle later with mem_addr=0x00100001, i_rdy 4 cycles after first
//    sampled edge, i_rdata=mem word.
//  - Load LAT=1: d_req, d_we=0, d_addr=0x10010008, memory word 0xDEADBEEF -> d_rdy at t0+3,
//    d_rdata=0xDEADBEEF, i_rdata unchanged.
//  - Store: d_we=1, d_be=4'b0011, d_wdata=0x12345678 -> single mem_en cycle with mem_we=1, mem_be=4'b0011;
//    d_rdy at t0+LAT+2; d_rdata unchanged.
//  - Fairness, MAX_STREAK=4: i_req and d_req held high continuously ->
//    grant order D,D,D,D,I,D,D,D,D,I,...; never 5 D grants in a row.
//  - Simultaneous first request: i_req and d_req rise in the same cycle with streak=0 ->
//    D completes first, then I. Exactly one rdy per access; never both rdy in one cycle.
//  - Reset mid-WAIT (LAT=3): assert reset during WAIT of a load -> no d_rdy, busy=0 immediately.
//    After release, re-issued load completes normally.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port, fixed-latency word memory between the instruction-fetch
// port and the load/store port; data wins by default, a streak limit keeps fetch alive.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LAT        = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_rdy,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int STK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_STREAK);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [STK_W-1:0] streak;
    logic             owner_d;
    logic             owner_st;
    logic             grant;
    logic             grant_d;
    logic             done;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant     = 1'b1;
                    // fetch is forced only once the data streak has hit its limit
                    grant_d   = d_req && !(i_req && (streak == STK_MAX));
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            streak    <= '0;
            owner_d   <= 1'b0;
            owner_st  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            i_rdy     <= 1'b0;
            d_rdy     <= 1'b0;
            i_rdata   <= 32'h0;
            d_rdata   <= 32'h0;
            busy      <= 1'b0;
        end else begin
            mem_en <= grant;
            i_rdy  <= done && !owner_d;
            d_rdy  <= done && owner_d;
            busy   <= (state_nxt != IDLE);

            if (grant) begin
                owner_d   <= grant_d;
                owner_st  <= grant_d && d_we;
                mem_we    <= grant_d && d_we;
                mem_be    <= (grant_d && d_we) ? d_be : 4'hF;
                mem_addr  <= grant_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
                mem_wdata <= grant_d ? d_wdata : 32'h0;
                if (grant_d && i_req)
                    streak <= (streak == STK_MAX) ? STK_MAX : streak + STK_W'(1);
                else
                    streak <= '0;
            end

            if (state == ISSUE)
                cnt <= CNT_W'(LAT - 1);
            else if ((state == WAIT) && (cnt != '0))
                cnt <= cnt - CNT_W'(1);

            // stores leave d_rdata untouched
            if (done) begin
                if (!owner_d)
                    i_rdata <= mem_rdata;
                else if (!owner_st)
                    d_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: three instances (LAT=1,2,3) against a transaction-timeline
// model, plus directed scenarios with hand-computed expectations.
module tb_mips_mem_arbiter;
    localparam int MAXS = 4;

    logic        clk;
    logic        reset;
    logic        i_req     [3];
    logic [31:0] i_addr    [3];
    logic        i_rdy     [3];
    logic [31:0] i_rdata   [3];
    logic        d_req     [3];
    logic        d_we      [3];
    logic [3:0]  d_be      [3];
    logic [31:0] d_addr    [3];
    logic [31:0] d_wdata   [3];
    logic        d_rdy     [3];
    logic [31:0] d_rdata   [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [3:0]  mem_be    [3];
    logic [29:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic        busy      [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit         log0[$];
    int         en_cnt0;
    logic       last_we0;
    logic [3:0] last_be0;

    logic [31:0] ref_mem [3][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] bmem [256];
        int          rcnt = 0;
        logic [7:0]  ridx = 8'h0;

        mips_mem_arbiter #(.ADDR_W(32), .LAT(g + 1), .MAX_STREAK(MAXS)) u_dut (
            .clk(clk), .reset(reset),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdy(i_rdy[g]), .i_rdata(i_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
            .d_wdata(d_wdata[g]), .d_rdy(d_rdy[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        initial begin
            for (int w = 0; w < 256; w++) bmem[w] = 32'h5A00_0000 + 32'(g) * 32'h0001_0000 + 32'(w);
            if (g == 0) bmem[2] = 32'hDEAD_BEEF;
        end

        // read data is valid only in the cycle exactly LAT after the mem_en cycle
        always @(posedge clk) begin
            if (rcnt > 0) rcnt <= rcnt - 1;
            if (mem_en[g]) begin
                rcnt <= g + 1;
                ridx <= mem_addr[g][7:0];
                if (mem_we[g])
                    for (int b = 0; b < 4; b++)
                        if (mem_be[g][b]) bmem[mem_addr[g][7:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
        end
        assign mem_rdata[g] = (rcnt == 1) ? bmem[ridx] : (32'hE0E0_0000 | 32'(ridx));
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] cycle=%0d got=%h want=%h", nm, k, cyc, act, exp);
        end
    endtask

    // Timeline model: a grant at cycle t gives mem_en at t+1, rdy at t+LAT+2, idle again at t+LAT+3.
    int          tg[3], free_at[3], drun[3];
    bit          own_d[3], st[3], m_st[3];
    logic [3:0]  tbe[3], m_be[3];
    logic [29:0] taddr[3], m_addr[3];
    logic [31:0] twd[3], rdv[3], xi[3], xd[3], m_wd[3];
    logic        m_we[3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 256; w++) ref_mem[k][w] = 32'h5A00_0000 + 32'(k) * 32'h0001_0000 + 32'(w);
            tg[k] = -100; free_at[k] = 0; drun[k] = 0;
        end
        ref_mem[0][2] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int  lat, c;
                bit  gd;
                lat = k + 1;
                c   = cyc;
                if (!reset) begin
                    tg[k] = -100; free_at[k] = 0; drun[k] = 0;
                    xi[k] = 0; xd[k] = 0; m_we[k] = 0; m_be[k] = 0; m_addr[k] = 0; m_wd[k] = 0; m_st[k] = 0;
                end else begin
                    if (c == tg[k] + 1) begin
                        m_we[k] = st[k]; m_be[k] = tbe[k]; m_addr[k] = taddr[k]; m_wd[k] = twd[k]; m_st[k] = st[k];
                    end
                    if (c == tg[k] + lat + 2) begin
                        if (!own_d[k]) xi[k] = rdv[k];
                        else if (!st[k]) xd[k] = rdv[k];
                    end
                end
                chk("busy", k, 32'(busy[k]), 32'(c > tg[k] && c <= tg[k] + lat + 2));
                chk("mem_en", k, 32'(mem_en[k]), 32'(c == tg[k] + 1));
                chk("i_rdy", k, 32'(i_rdy[k]), 32'(c == tg[k] + lat + 2 && !own_d[k]));
                chk("d_rdy", k, 32'(d_rdy[k]), 32'(c == tg[k] + lat + 2 && own_d[k]));
                chk("both_rdy", k, 32'(i_rdy[k] & d_rdy[k]), 32'd0);
                chk("i_rdata", k, i_rdata[k], xi[k]);
                chk("d_rdata", k, d_rdata[k], xd[k]);
                chk("mem_we", k, 32'(mem_we[k]), 32'(m_we[k]));
                chk("mem_be", k, 32'(mem_be[k]), 32'(m_be[k]));
                chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_addr[k]));
                if (!reset || m_st[k]) chk("mem_wdata", k, mem_wdata[k], m_wd[k]);

                if (k == 0) begin
                    if (reset && (i_rdy[0] || d_rdy[0])) log0.push_back(d_rdy[0]);
                    if (mem_en[0]) begin
                        en_cnt0++; last_we0 = mem_we[0]; last_be0 = mem_be[0];
                    end
                end

                if (reset && c >= free_at[k] && (i_req[k] || d_req[k])) begin
                    gd = d_req[k] && !(i_req[k] && drun[k] == MAXS);
                    drun[k] = (gd && i_req[k]) ? ((drun[k] < MAXS) ? drun[k] + 1 : MAXS) : 0;
                    tg[k] = c; own_d[k] = gd; st[k] = gd && d_we[k];
                    taddr[k] = gd ? d_addr[k][31:2] : i_addr[k][31:2];
                    tbe[k] = st[k] ? d_be[k] : 4'hF;
                    twd[k] = st[k] ? d_wdata[k] : 32'h0;
                    rdv[k] = ref_mem[k][taddr[k][7:0]];
                    if (st[k])
                        for (int b = 0; b < 4; b++)
                            if (d_be[k][b]) ref_mem[k][taddr[k][7:0]][8*b +: 8] = d_wdata[k][8*b +: 8];
                    free_at[k] = c + lat + 3;
                end
            end
        end
    end

    task automatic do_access(input int k, input bit isd, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output int t0, output int trdy);
        @(posedge clk); #1;
        t0 = cyc;
        if (isd) begin
            d_we[k] = we; d_be[k] = be; d_addr[k] = addr; d_wdata[k] = wd; d_req[k] = 1'b1;
        end else begin
            i_addr[k] = addr; i_req[k] = 1'b1;
        end
        trdy = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (isd ? d_rdy[k] : i_rdy[k]) begin
                trdy = cyc;
                break;
            end
        end
        if (trdy < 0) chk("rdy_timeout", k, 32'd0, 32'd1);
        @(posedge clk); #1;
        if (isd) d_req[k] = 1'b0;
        else     i_req[k] = 1'b0;
    endtask

    initial begin
        int t0, tr, ta, tra, tb, trb, tm, seen;
        logic [29:0] am;
        logic [31:0] rd;
        int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
            d_be[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
        end
        #2 reset = 1'b0;
        i_req[1] = 1'b1; i_addr[1] = 32'h0040_0004;
        d_req[1] = 1'b1; d_addr[1] = 32'h1001_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", 1, 32'(mem_en[1]), 32'd0);
        chk("rst_busy", 1, 32'(busy[1]), 32'd0);
        chk("rst_i_rdy", 1, 32'(i_rdy[1]), 32'd0);
        chk("rst_d_rdy", 1, 32'(d_rdy[1]), 32'd0);
        chk("rst_i_rdata", 1, i_rdata[1], 32'h0);
        chk("rst_d_rdata", 1, d_rdata[1], 32'h0);

        // release reset with only the fetch pending, LAT=2
        @(posedge clk); #1;
        reset = 1'b1; d_req[1] = 1'b0; t0 = cyc;
        tm = -1; tr = -1; am = '0; rd = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_en[1]) begin tm = cyc; am = mem_addr[1]; end
            if (i_rdy[1]) begin tr = cyc; rd = i_rdata[1]; break; end
        end
        chk("fetch_en_lat", 1, 32'(tm - t0), 32'd1);
        chk("fetch_mem_addr", 1, 32'(am), 32'h0010_0001);
        chk("fetch_rdy_lat", 1, 32'(tr - t0), 32'd4);
        chk("fetch_rdata", 1, rd, 32'h5A01_0001);
        @(posedge clk); #1;
        i_req[1] = 1'b0;

        // load, LAT=1
        do_access(0, 1, 0, 4'hF, 32'h1001_0008, 32'h0, t0, tr);
        chk("load_lat", 0, 32'(tr - t0), 32'd3);
        chk("load_rdata", 0, d_rdata[0], 32'hDEAD_BEEF);
        chk("load_i_rdata", 0, i_rdata[0], 32'h0);

        // partial store to the same word
        en_cnt0 = 0;
        do_access(0, 1, 1, 4'b0011, 32'h1001_0008, 32'h1234_5678, t0, tr);
        chk("store_en_cnt", 0, 32'(en_cnt0), 32'd1);
        chk("store_we", 0, 32'(last_we0), 32'd1);
        chk("store_be", 0, 32'(last_be0), 32'h3);
        chk("store_lat", 0, 32'(tr - t0), 32'd3);
        chk("store_d_rdata", 0, d_rdata[0], 32'hDEAD_BEEF);
        do_access(0, 1, 0, 4'hF, 32'h1001_0008, 32'h0, t0, tr);
        chk("reload_rdata", 0, d_rdata[0], 32'hDEAD_5678);

        // simultaneous first request: data first, then fetch
        log0.delete();
        fork
            do_access(0, 1, 0, 4'hF, 32'h1001_0010, 32'h0, ta, tra);
            do_access(0, 0, 0, 4'hF, 32'h0040_0010, 32'h0, tb, trb);
        join
        chk("simul_count", 0, 32'(log0.size()), 32'd2);
        if (log0.size() == 2) begin
            chk("simul_first_d", 0, 32'(log0[0]), 32'd1);
            chk("simul_second_i", 0, 32'(log0[1]), 32'd0);
        end
        chk("simul_d_lat", 0, 32'(tra - ta), 32'd3);
        chk("simul_i_lat", 0, 32'(trb - tb), 32'd7);
        chk("simul_i_rdata", 0, i_rdata[0], 32'h5A00_0004);

        // fairness with both requests held high
        log0.delete();
        @(posedge clk); #1;
        d_we[0] = 0; d_be[0] = 4'hF; d_addr[0] = 32'h1001_0020; i_addr[0] = 32'h0040_0020;
        i_req[0] = 1'b1; d_req[0] = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (log0.size() >= 10) break;
        end
        chk("fair_count", 0, 32'(log0.size()), 32'd10);
        for (int n = 0; n < 10; n++)
            if (n < log0.size()) chk("fair_order", n, 32'(log0[n]), 32'(exp_order[n]));
        @(posedge clk); #1;
        i_req[0] = 1'b0; d_req[0] = 1'b0;

        // reset during WAIT of a load, LAT=3
        @(posedge clk); #1;
        t0 = cyc;
        d_we[2] = 0; d_be[2] = 4'hF; d_addr[2] = 32'h1001_0040; d_req[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midwait_busy", 2, 32'(busy[2]), 32'd1);
        reset = 1'b0; d_req[2] = 1'b0;
        #1;
        chk("midrst_busy", 2, 32'(busy[2]), 32'd0);
        chk("midrst_d_rdy", 2, 32'(d_rdy[2]), 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_rdy[2]) seen = 1;
        end
        chk("midrst_no_rdy", 2, 32'(seen), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        do_access(2, 1, 0, 4'hF, 32'h1001_0040, 32'h0, t0, tr);
        chk("reissue_lat", 2, 32'(tr - t0), 32'd5);
        chk("reissue_rdata", 2, d_rdata[2], 32'h5A02_0010);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
